// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES constants, datapath typedefs and GF(2^8) helpers. The round
// datapath stages (MixColumns, AddRoundKey) import this package so that byte
// order and field arithmetic stay consistent across the pipeline.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NB   = 4;   // state columns, state is NB x NB bytes
  localparam int WORD = 8;   // byte width in bits
  localparam int NR   = 10;  // number of rounds for AES-128

  localparam logic [WORD-1:0] RCON_INIT = 8'h01;
  localparam logic [WORD-1:0] GF_POLY   = 8'h1B;

  typedef logic [NB*NB*WORD-1:0] state_t;
  typedef logic [NB*WORD-1:0]    word_t;
  typedef logic [WORD-1:0]       byte_t;
  typedef logic [3:0]            round_t;

  localparam round_t ROUND_FIRST = 4'd0;
  localparam round_t ROUND_LAST  = round_t'(NR);

  // Multiply by x in GF(2^8); the carry out of bit 7 folds back through the
  // reduction polynomial.
  function automatic byte_t xtime(input byte_t b);
    byte_t shifted;
    shifted = {b[WORD-2:0], 1'b0};
    return b[WORD-1] ? (shifted ^ GF_POLY) : shifted;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box, one byte in and one byte out.
// Ports:
//   i_byte  input  8  byte to substitute
//   o_byte  output 8  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
  import aes_pkg::*;
(
  input  logic [WORD-1:0] i_byte,
  output logic [WORD-1:0] o_byte
);

  // Written in the usual FIPS row order, so the leftmost literal byte is the
  // substitution for 8'h00. With a descending packed range that leftmost
  // element sits at index 255, hence the lookup uses the inverted input.
  localparam logic [255:0][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    o_byte = SBOX_TABLE[~i_byte];
  end

endmodule

// File: rtl/add_round_key.sv
// ---------------------------------------------------------------------------
// add_round_key
// AES-128 AddRoundKey stage with an on-the-fly key schedule. Each accepted
// state is XORed with the current round key and registered; the schedule then
// advances one round, rewinding to the cipher key after round NR. Only the
// cipher key and the current round key are stored, plus four S-boxes for
// SubWord.
//
// Optional build macro: AES_ARK_ROUND_PORT_EN adds the o_round output and its
// register. The datapath is the same with or without it.
//
// Ports:
//   clk         input   1    clock, rising edge
//   rst         input   1    synchronous active-high reset
//   i_key_load  input   1    load a new cipher key this cycle
//   i_key       input   128  cipher key, column-major, byte 0 in [127:120]
//   i_valid     input   1    i_block valid this cycle
//   i_block     input   128  state from MixColumns, same byte order
//   o_block     output  128  registered i_block XOR round key
//   o_valid     output  1    o_block valid
//   o_round     output  4    round index used for o_block (optional)
//   o_last      output  1    o_block used round key NR
// ---------------------------------------------------------------------------
module add_round_key
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_key_load,
  input  logic [NB*NB*WORD-1:0]  i_key,
  input  logic                   i_valid,
  input  logic [NB*NB*WORD-1:0]  i_block,
  output logic [NB*NB*WORD-1:0]  o_block,
  output logic                   o_valid,
`ifdef AES_ARK_ROUND_PORT_EN
  output logic [3:0]             o_round,
`endif
  output logic                   o_last
);

  state_t ck_q, ck_d;
  state_t rk_q, rk_d;
  round_t round_q, round_d;
  byte_t  rcon_q, rcon_d;

  state_t o_block_q, o_block_d;
  logic   o_valid_q, o_valid_d;
  logic   o_last_q, o_last_d;
`ifdef AES_ARK_ROUND_PORT_EN
  round_t o_round_q, o_round_d;
`endif

  // Schedule position seen by a block this cycle. A key load takes effect
  // immediately, so a block presented alongside it uses round 0 of the new key.
  state_t sched_key;
  round_t sched_round;
  byte_t  sched_rcon;

  word_t  w0, w1, w2, w3;
  word_t  rot_w, sub_w, t_w;
  word_t  n0, n1, n2, n3;
  state_t next_key;

  always_comb begin
    sched_key   = rk_q;
    sched_round = round_q;
    sched_rcon  = rcon_q;
    if (i_key_load) begin
      sched_key   = i_key;
      sched_round = ROUND_FIRST;
      sched_rcon  = RCON_INIT;
    end
  end

  // One step of the AES-128 key expansion. RotWord moves the top byte of w3
  // to the bottom before substitution.
  always_comb begin
    w0    = sched_key[127:96];
    w1    = sched_key[95:64];
    w2    = sched_key[63:32];
    w3    = sched_key[31:0];
    rot_w = {w3[23:0], w3[31:24]};
  end

  for (genvar g = 0; g < NB; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (rot_w[g*WORD +: WORD]),
      .o_byte (sub_w[g*WORD +: WORD])
    );
  end

  always_comb begin
    t_w      = sub_w ^ {sched_rcon, 24'h000000};
    n0       = w0 ^ t_w;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    ck_d      = ck_q;
    rk_d      = rk_q;
    round_d   = round_q;
    rcon_d    = rcon_q;
    o_block_d = o_block_q;
    o_valid_d = 1'b0;
    o_last_d  = o_last_q;
`ifdef AES_ARK_ROUND_PORT_EN
    o_round_d = o_round_q;
`endif

    if (i_key_load) begin
      ck_d    = i_key;
      rk_d    = i_key;
      round_d = ROUND_FIRST;
      rcon_d  = RCON_INIT;
    end

    if (i_valid) begin
      o_block_d = i_block ^ sched_key;
      o_valid_d = 1'b1;
      o_last_d  = (sched_round == ROUND_LAST);
`ifdef AES_ARK_ROUND_PORT_EN
      o_round_d = sched_round;
`endif
      // A key load forces round 0, so the wrap branch only ever sees ck_q.
      if (sched_round == ROUND_LAST) begin
        rk_d    = ck_q;
        round_d = ROUND_FIRST;
        rcon_d  = RCON_INIT;
      end else begin
        rk_d    = next_key;
        round_d = sched_round + 4'd1;
        rcon_d  = xtime(sched_rcon);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ck_q      <= '0;
      rk_q      <= '0;
      round_q   <= ROUND_FIRST;
      rcon_q    <= RCON_INIT;
      o_block_q <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      ck_q      <= ck_d;
      rk_q      <= rk_d;
      round_q   <= round_d;
      rcon_q    <= rcon_d;
      o_block_q <= o_block_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
    end
  end

`ifdef AES_ARK_ROUND_PORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_round_q <= ROUND_FIRST;
    end else begin
      o_round_q <= o_round_d;
    end
  end

  assign o_round = o_round_q;
`endif

  assign o_block = o_block_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;

endmodule

// File: doc/add_round_key.md
# add_round_key

AES-128 AddRoundKey stage with an on-the-fly key schedule, sitting directly downstream of the MixColumns stage in the round datapath. Each accepted 128-bit state is XORed with the current round key, registered, and emitted one cycle later. After each accepted block the internal schedule advances to the next round key. After the final round it rewinds to the cipher key for the next block. It replaces a stored 11-entry key table with one key register pair and a 4-byte S-box.

## Interface
- NB, 4, number of state columns (state is NB x NB bytes)
- WORD, 8, byte width in bits
- NR, 10, number of rounds; the schedule wraps after round key NR
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- i_key_load  input  1  load new cipher key this cycle
- i_key  input  NB*NB*WORD  128-bit cipher key, column-major, byte 0 in [127:120]
- i_valid  input  1  i_block valid this cycle
- i_block  input  NB*NB*WORD  128-bit state, column-major, same byte order as MixColumns output
- o_block  output  NB*NB*WORD  registered i_block XOR round key
- o_valid  output  1  o_block valid
- o_last  output  1  o_block used round key NR
- o_round  output  4  round index used for o_block (only with AES_ARK_ROUND_PORT_EN)

## Operation
- Internal state:
  - ck_q: cipher key copy
  - rk_q: current round key
  - round_q: 0..NR
  - rcon_q: current Rcon byte
- Key load (i_key_load=1):
  - ck_q <= i_key, rk_q <= i_key, round_q <= 0, rcon_q <= 8'h01.
- Block accept (i_valid=1, i_key_load=0):
  - o_block <= i_block ^ rk_q; o_valid <= 1; o_last <= (round_q==NR).
  - If round_q < NR: rk_q <= next(rk_q, rcon_q); round_q++; rcon_q <= xtime(rcon_q).
  - If round_q == NR: rk_q <= ck_q; round_q <= 0; rcon_q <= 8'h01 (wrap).
- next(): words w0..w3 = rk[127:96]..rk[31:0].
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - Next words: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- xtime: GF(2^8) doubling, reduction polynomial 8'h1B. Rcon after 8'h80 is 8'h1B, then 8'h36.
- Simultaneous i_key_load and i_valid:
  - The key load wins and the schedule initialises from i_key.
  - The block is XORed with i_key (round 0) and accepted; o_valid <= 1.
  - The schedule then stands at round 1 of the new key.
- Idle (i_valid=0): o_valid <= 0; o_block, o_last hold; schedule holds.
- No backpressure. Upstream may present a block every cycle.
- Blocks before any key load use the reset key (all zero).

## Timing
- Latency: 1 cycle, i_valid to o_valid. Throughput: 1 block/cycle.
- Round key for the next block is available the cycle after acceptance. The next() path (S-box plus XOR) is the critical path.
- Reset values:
  - o_block=0, o_valid=0, o_last=0, o_round=0.
  - ck_q=0, rk_q=0, round_q=0, rcon_q=8'h01.
- Reset mid-sequence: all state returns to reset values in the same edge; any in-flight block is discarded.
- Wrap boundary: the block at round NR sets o_last=1. The following block uses ck_q with round 0.

## Configuration
- AES_ARK_ROUND_PORT_EN:
  - Defined: port o_round exists, registered with o_block, and carries the round index used.
  - Undefined: port o_round is absent, and the 4-bit output register is not built.
  - Datapath behaviour is identical either way.

## Structure
- Shared package aes_pkg:
  - Constants: NB, WORD, NR, RCON_INIT=8'h01, GF_POLY=8'h1B.
  - Typedefs: state_t (128-bit), word_t (32-bit), byte_t.
  - Function: xtime, shared with the MixColumns stage.
- Sub-module aes_sbox: combinational forward S-box, one byte in, one byte out. Instantiated 4x for SubWord.

## Test plan
- Reset then no key load: i_block=0, i_valid=1 -> next cycle o_block=0, o_valid=1, o_last=0.
- Load key 2b7e151628aed2a6abf7158809cf4f3c, then one block i_block=0:
  - o_block=2b7e151628aed2a6abf7158809cf4f3c (round 0).
  - Second block i_block=0 -> o_block=a0fafe1788542cb123a339392a6c7605.
- Same key, 11 back-to-back zero blocks:
  - 11th o_block=d014f9a8c9ee2589e13f0cc8b6630ca6 with o_last=1.
  - 12th block -> o_block equals the cipher key, o_last=0 (wrap).
- i_key_load and i_valid in the same cycle with i_block=ffff…ff, new key K -> o_block=~K; next zero block -> round-1 key of K.
- Assert rst after 5 blocks of a sequence -> o_valid=0 and o_block=0 next cycle; a subsequent zero block without reload -> o_block=0.
- Gaps: i_valid pulses separated by idle cycles -> keys advance only on accepted blocks; o_valid drops during idle cycles and o_block holds.
